red_pitaya_ams_pwm_ramp: RTL and testbench
==========================================

// Module: red_pitaya_ams_pwm_ramp
// PURPOSE
//  Parametrised successor to the AMS PWM DAC register block. Provides CH slow-DAC channels of DW bits, each with a
//  bus-writable shadow register, a committed target and a slew-limited live value. It also generates a PWM bit per
//  channel from the live value. Sits on the system bus beside the XADC path and drives the analog PWM DAC pins.
// PARAMETERS
//  CH      4                          number of channels (1..8)
//  DW      24                         channel value width (PB..24)
//  PB      8                          PWM resolution; PWM period = 2^PB clk_i cycles
//  PRESC   256                        clk_i cycles per slew tick (>=1)
//  RST_VAL {24'h9C0000,24'h750000,24'h4E0000,24'h0F0000}  CH*DW reset values; ch0 = LSBs
// PORTS
//  clk_i      in   1      clock; the only clock
//  rstn_i     in   1      reset, asynchronous, active-low
//  sys_addr   in   32     bus address; only [19:0] decoded
//  sys_wdata  in   32     bus write data
//  sys_wen    in   1      bus write enable, 1-cycle strobe
//  sys_ren    in   1      bus read enable, 1-cycle strobe
//  sys_rdata  out  32     registered read data
//  sys_err    out  1      bus error; always 0
//  sys_ack    out  1      bus acknowledge
//  dac_o      out  CH*DW  live channel values; ch n = [n*DW +: DW]
//  pwm_o      out  CH     PWM bit per channel
//  busy_o     out  1      OR of per-channel ramping flags, or commit pending
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - shadow, target and live all = RST_VAL; CTRL = 0; STEP = 0
//   - prescaler, PWM counter and pending flag = 0
//   - outputs: sys_ack = 0, sys_err = 0, sys_rdata = 0, pwm_o = 0, busy_o = 0
//   - reset mid-ramp abandons the ramp; no partial state survives
//  Register map (byte address, word-aligned):
//   0x00 CTRL    [0] AUTO; [1] COMMIT, write-1 strobe, reads 0
//   0x04 STATUS  RO; [CH-1:0] ramping flags; [8] pending
//   0x08 STEP    [DW-1:0] slew step per tick; 0 = no slew limit
//   0x20+4n      shadow n, [DW-1:0]; upper bits of wdata ignored, read back zero-extended
//   0x40+4n      live n, RO
//   other/RO     write ignored; read returns 0; ack still given
//  Bus: sys_ack and sys_rdata registered, asserted exactly 1 cycle after sys_wen|sys_ren; sys_ack = 0 otherwise.
//   A register write is visible to a read that is issued on the following cycle.
//  Commit:
//   - AUTO=1: a shadow write copies into the target 1 cycle after the write
//   - AUTO=0: targets change only on commit. Writing COMMIT=1 sets pending.
//   - when pending is set and the PWM counter = 2^PB-1, all targets <= shadows and pending clears on that same edge
//   - COMMIT while pending is set: no effect, single pending only
//   - AUTO and COMMIT written together: AUTO wins, the write is treated as an AUTO write
//  Slew:
//   - prescaler counts 0..PRESC-1 and wraps; tick = (prescaler == PRESC-1)
//   - STEP=0: live <= target on the next cycle, independent of tick
//   - STEP>0: on each tick, live moves toward target by min(STEP, |target-live|)
//   - arithmetic uses DW+1 bits; live never overshoots the target and never wraps
//   - ramping[n] = (live[n] != target[n])
//   - target changed mid-ramp: the ramp redirects from the current live value; no restart delay
//  PWM:
//   - free-running PB-bit counter
//   - pwm_o[n] registered: 1 while counter < live[n][DW-1 -: PB]
//   - duty 0 gives constant 0; the maximum code gives a high time of 2^PB-1 out of every 2^PB cycles
// TESTING
//  - Reset: assert rstn_i mid-ramp -> all outputs immediately reset; dac_o = RST_VAL; STATUS = 0.
//  - AUTO=1, STEP=0, write 0x20 = 24'h123456 -> dac_o[23:0] = 24'h123456 within 2 cycles; readback 0x40 matches.
//  - AUTO=1, STEP=0x10000, PRESC=4, ch1 0x4E0000 -> 0x500000 -> two ticks; ch1 busy until live = 0x500000; no overshoot.
//  - AUTO=0, write shadows, then COMMIT mid-period -> targets update only at PWM counter wrap.
//    A second COMMIT before the wrap is a no-op.
//  - PWM: ch live = 24'h400000, PB=8 -> pwm_o high for 64 of 256 cycles; code 0 -> always 0.
//  - Bus: read unmapped 0x7C -> ack next cycle, rdata = 0, err = 0; write 0x40 -> live unchanged.

Source files
------------

// File: rtl/red_pitaya_ams_pwm_ramp.sv
// Slow-DAC register block: per-channel shadow/target/live values with slew-limited ramping,
// PWM-frame-synchronous commit and one PWM bit per channel.
module red_pitaya_ams_pwm_ramp #(
  parameter int unsigned      CH      = 4,
  parameter int unsigned      DW      = 24,
  parameter int unsigned      PB      = 8,
  parameter int unsigned      PRESC   = 256,
  parameter logic [CH*DW-1:0] RST_VAL = {24'h9C0000, 24'h750000, 24'h4E0000, 24'h0F0000}
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [31:0]      sys_addr,
  input  logic [31:0]      sys_wdata,
  input  logic             sys_wen,
  input  logic             sys_ren,
  output logic [31:0]      sys_rdata,
  output logic             sys_err,
  output logic             sys_ack,
  output logic [CH*DW-1:0] dac_o,
  output logic [CH-1:0]    pwm_o,
  output logic             busy_o
);

  localparam int unsigned    PSW        = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESC - 1);
  localparam logic [PB-1:0]  PWM_LAST   = {PB{1'b1}};
  localparam logic [17:0]    IDX_CTRL   = 18'd0;
  localparam logic [17:0]    IDX_STATUS = 18'd1;
  localparam logic [17:0]    IDX_STEP   = 18'd2;
  localparam logic [17:0]    IDX_SHADOW = 18'd8;
  localparam logic [17:0]    IDX_LIVE   = 18'd16;

  // One slew step toward tgt, clamped so the result never passes the target.
  function automatic logic [DW-1:0] slew_f(input logic [DW-1:0] live,
                                           input logic [DW-1:0] tgt,
                                           input logic [DW-1:0] step);
    logic [DW:0] l_ext;
    logic [DW:0] t_ext;
    logic [DW:0] s_ext;
    l_ext = {1'b0, live};
    t_ext = {1'b0, tgt};
    s_ext = {1'b0, step};
    if (t_ext > l_ext) begin
      slew_f = ((t_ext - l_ext) > s_ext) ? DW'(l_ext + s_ext) : tgt;
    end else if (l_ext > t_ext) begin
      slew_f = ((l_ext - t_ext) > s_ext) ? DW'(l_ext - s_ext) : tgt;
    end else begin
      slew_f = live;
    end
  endfunction

  logic [PSW-1:0] presc_r,   presc_nxt_s;
  logic [PB-1:0]  pwm_cnt_r, pwm_cnt_nxt_s;
  logic           auto_r,    auto_nxt_s;
  logic           pending_r, pending_nxt_s;
  logic [DW-1:0]  step_r,    step_nxt_s;
  logic [DW-1:0]  shadow_r [CH];
  logic [DW-1:0]  shadow_nxt_s [CH];
  logic [DW-1:0]  target_r [CH];
  logic [DW-1:0]  target_nxt_s [CH];
  logic [DW-1:0]  live_r [CH];
  logic [DW-1:0]  live_nxt_s [CH];
  logic [CH-1:0]  pwm_r,     pwm_nxt_s;
  logic [CH-1:0]  ramp_s,    ramp_nxt_s;
  logic [CH-1:0]  sh_wr_s;
  logic           busy_r,    busy_nxt_s;
  logic           ack_r,     ack_nxt_s;
  logic [31:0]    rdata_r,   rdata_nxt_s;
  logic [31:0]    rd_mux_s;
  logic [17:0]    idx_s;
  logic           tick_s;
  logic           ctrl_wr_s;
  logic           commit_req_s;
  logic           commit_now_s;
  logic           unused_bits_s;

  assign unused_bits_s = ^{sys_addr[31:20], sys_addr[1:0], sys_wdata[31:DW]};

  // Next-state logic for control, commit, slew and PWM compare.
  always_comb begin
    idx_s         = sys_addr[19:2];
    tick_s        = (presc_r == PRESC_LAST);
    ctrl_wr_s     = sys_wen && (idx_s == IDX_CTRL);
    // AUTO set in the same write overrides COMMIT
    commit_req_s  = ctrl_wr_s && sys_wdata[1] && !sys_wdata[0];
    commit_now_s  = pending_r && (pwm_cnt_r == PWM_LAST);
    presc_nxt_s   = tick_s ? {PSW{1'b0}} : presc_r + PSW'(1);
    pwm_cnt_nxt_s = pwm_cnt_r + PB'(1);
    auto_nxt_s    = ctrl_wr_s ? sys_wdata[0] : auto_r;
    step_nxt_s    = (sys_wen && (idx_s == IDX_STEP)) ? sys_wdata[DW-1:0] : step_r;
    if (commit_now_s) begin
      pending_nxt_s = 1'b0;
    end else if (commit_req_s) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
    for (int n = 0; n < CH; n++) begin
      sh_wr_s[n]      = sys_wen && (idx_s == (IDX_SHADOW + 18'(n)));
      shadow_nxt_s[n] = sh_wr_s[n] ? sys_wdata[DW-1:0] : shadow_r[n];
      if (sh_wr_s[n] && auto_r) begin
        target_nxt_s[n] = sys_wdata[DW-1:0];
      end else if (commit_now_s) begin
        target_nxt_s[n] = shadow_r[n];
      end else begin
        target_nxt_s[n] = target_r[n];
      end
      if (step_r == {DW{1'b0}}) begin
        live_nxt_s[n] = target_r[n];
      end else if (tick_s) begin
        live_nxt_s[n] = slew_f(live_r[n], target_r[n], step_r);
      end else begin
        live_nxt_s[n] = live_r[n];
      end
      ramp_s[n]     = (live_r[n] != target_r[n]);
      ramp_nxt_s[n] = (live_nxt_s[n] != target_nxt_s[n]);
      pwm_nxt_s[n]  = (pwm_cnt_r < live_r[n][DW-1 -: PB]);
    end
    busy_nxt_s = (|ramp_nxt_s) || pending_nxt_s;
  end

  // Bus read mux and acknowledge.
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      IDX_CTRL:   rd_mux_s = {31'd0, auto_r};
      IDX_STATUS: begin
        rd_mux_s[CH-1:0] = ramp_s;
        rd_mux_s[8]      = pending_r;
      end
      IDX_STEP:   rd_mux_s = 32'(step_r);
      default: begin
        for (int n = 0; n < CH; n++) begin
          rd_mux_s = rd_mux_s
                   | ((idx_s == (IDX_SHADOW + 18'(n))) ? 32'(shadow_r[n]) : 32'd0)
                   | ((idx_s == (IDX_LIVE + 18'(n)))   ? 32'(live_r[n])   : 32'd0);
        end
      end
    endcase
    rdata_nxt_s = sys_ren ? rd_mux_s : 32'd0;
    ack_nxt_s   = sys_wen || sys_ren;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_r   <= {PSW{1'b0}};
      pwm_cnt_r <= {PB{1'b0}};
      auto_r    <= 1'b0;
      pending_r <= 1'b0;
      step_r    <= {DW{1'b0}};
      pwm_r     <= {CH{1'b0}};
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      rdata_r   <= 32'd0;
      for (int n = 0; n < CH; n++) begin
        shadow_r[n] <= RST_VAL[n*DW +: DW];
        target_r[n] <= RST_VAL[n*DW +: DW];
        live_r[n]   <= RST_VAL[n*DW +: DW];
      end
    end else begin
      presc_r   <= presc_nxt_s;
      pwm_cnt_r <= pwm_cnt_nxt_s;
      auto_r    <= auto_nxt_s;
      pending_r <= pending_nxt_s;
      step_r    <= step_nxt_s;
      pwm_r     <= pwm_nxt_s;
      busy_r    <= busy_nxt_s;
      ack_r     <= ack_nxt_s;
      rdata_r   <= rdata_nxt_s;
      for (int n = 0; n < CH; n++) begin
        shadow_r[n] <= shadow_nxt_s[n];
        target_r[n] <= target_nxt_s[n];
        live_r[n]   <= live_nxt_s[n];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_dac
    assign dac_o[g*DW +: DW] = live_r[g];
  end

  assign pwm_o     = pwm_r;
  assign busy_o    = busy_r;
  assign sys_ack   = ack_r;
  assign sys_rdata = rdata_r;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_ams_pwm_ramp.sv
// Directed bench for red_pitaya_ams_pwm_ramp: register-map vector table plus hand-written
// sequences for slew, frame-synchronous commit, PWM duty and reset mid-ramp.
`timescale 1ns/1ps
module tb_red_pitaya_ams_pwm_ramp;

  localparam int CH    = 4;
  localparam int DW    = 24;
  localparam int PB    = 8;
  localparam int PRESC = 4;
  localparam logic [CH*DW-1:0] RST_VAL = {24'h9C0000, 24'h750000, 24'h4E0000, 24'h0F0000};

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic [31:0]      sys_addr = 32'd0;
  logic [31:0]      sys_wdata = 32'd0;
  logic             sys_wen = 1'b0;
  logic             sys_ren = 1'b0;
  logic [31:0]      sys_rdata;
  logic             sys_err;
  logic             sys_ack;
  logic [CH*DW-1:0] dac_o;
  logic [CH-1:0]    pwm_o;
  logic             busy_o;

  red_pitaya_ams_pwm_ramp #(.CH(CH), .DW(DW), .PB(PB), .PRESC(PRESC), .RST_VAL(RST_VAL)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err),
    .sys_ack(sys_ack), .dac_o(dac_o), .pwm_o(pwm_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference PWM frame position: free-running from reset release.
  logic [7:0] tb_cnt;
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) tb_cnt <= 8'd0;
    else         tb_cnt <= tb_cnt + 8'd1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] ch_val(input int n);
    return 32'(dac_o[n*DW +: DW]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(negedge clk_i);
    sys_wen = 1'b0;
    check("wr_ack", {31'd0, sys_ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_i);
    sys_addr = a; sys_ren = 1'b1;
    @(negedge clk_i);
    sys_ren = 1'b0;
    d = sys_rdata;
    check("rd_ack", {31'd0, sys_ack}, 32'd1);
    check("rd_err", {31'd0, sys_err}, 32'd0);
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, e);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prev, cur;
    int nchg, c1, c2;
    logic done, hit;
    int hi [CH];

    // ---------------- reset state ----------------
    #12;
    for (int n = 0; n < CH; n++) check("rst_dac", ch_val(n), 32'(RST_VAL[n*DW +: DW]));
    check("rst_ack",  {31'd0, sys_ack}, 32'd0);
    check("rst_err",  {31'd0, sys_err}, 32'd0);
    check("rst_rdata", sys_rdata, 32'd0);
    check("rst_pwm",  {28'd0, pwm_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // ---------------- register map table ----------------
    add(1'b0, 32'h00, 32'h0,         32'h0);
    add(1'b0, 32'h04, 32'h0,         32'h0);
    add(1'b0, 32'h08, 32'h0,         32'h0);
    add(1'b0, 32'h24, 32'h0,         32'h004E_0000);
    add(1'b0, 32'h4C, 32'h0,         32'h009C_0000);
    add(1'b1, 32'h28, 32'hFFAB_CDEF, 32'h0);
    add(1'b0, 32'h28, 32'h0,         32'h00AB_CDEF);
    add(1'b0, 32'h48, 32'h0,         32'h0075_0000);
    add(1'b1, 32'h08, 32'h1234_5678, 32'h0);
    add(1'b0, 32'h08, 32'h0,         32'h0034_5678);
    add(1'b1, 32'h08, 32'h0,         32'h0);
    add(1'b1, 32'h44, 32'h0011_1111, 32'h0);
    add(1'b0, 32'h44, 32'h0,         32'h004E_0000);
    add(1'b1, 32'h7C, 32'h5A5A_5A5A, 32'h0);
    add(1'b0, 32'h7C, 32'h0,         32'h0);
    add(1'b1, 32'h00, 32'h3,         32'h0);
    add(1'b0, 32'h00, 32'h0,         32'h1);
    add(1'b0, 32'h04, 32'h0,         32'h0);
    add(1'b1, 32'h28, 32'h0075_0000, 32'h0);
    add(1'b0, 32'h48, 32'h0,         32'h0075_0000);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        read_check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end
    end

    // ---------------- read issued the cycle after a write; ack lasts one cycle ----------------
    @(negedge clk_i);
    sys_addr = 32'h08; sys_wdata = 32'h0000_0ABC; sys_wen = 1'b1;
    @(negedge clk_i);
    sys_wen = 1'b0; sys_ren = 1'b1;
    @(negedge clk_i);
    sys_ren = 1'b0;
    check("wr_rd_b2b", sys_rdata, 32'h0000_0ABC);
    @(negedge clk_i);
    check("ack_one_cycle", {31'd0, sys_ack}, 32'd0);
    bus_write(32'h08, 32'h0);

    // ---------------- AUTO=1, STEP=0 direct update ----------------
    bus_write(32'h20, 32'h0012_3456);
    check("auto_live_lag", ch_val(0), 32'h000F_0000);
    check("auto_busy_1cyc", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    check("auto_live", ch_val(0), 32'h0012_3456);
    check("auto_busy_clr", {31'd0, busy_o}, 32'd0);
    read_check("auto_rd_live", 32'h40, 32'h0012_3456);

    // ---------------- slew upward, two ticks ----------------
    bus_write(32'h08, 32'h0001_0000);
    bus_write(32'h24, 32'h0050_0000);
    check("slew_busy_start", {31'd0, busy_o}, 32'd1);
    prev = ch_val(1); nchg = 0; c1 = 0; c2 = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!done) begin
        @(negedge clk_i);
        cur = ch_val(1);
        if (cur != prev) begin
          nchg++;
          check("slew_inc", cur - prev, 32'h0001_0000);
          if (nchg == 1) c1 = c;
          else c2 = c;
        end
        check("slew_busy", {31'd0, busy_o}, {31'd0, cur != 32'h0050_0000});
        prev = cur;
        done = (cur == 32'h0050_0000);
      end
    end
    check("slew_done", {31'd0, done}, 32'd1);
    check("slew_ticks", nchg, 32'd2);
    check("slew_tick_gap", c2 - c1, PRESC);

    // ---------------- slew downward, gap smaller than STEP ----------------
    bus_write(32'h2C, 32'h009B_8000);
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!done) begin
        @(negedge clk_i);
        check("slew_no_undershoot", {31'd0, ch_val(3) >= 32'h009B_8000}, 32'd1);
        done = (ch_val(3) == 32'h009B_8000);
      end
    end
    check("slew_down_done", {31'd0, done}, 32'd1);
    bus_write(32'h08, 32'h0);

    // ---------------- AUTO=0 commit at PWM frame wrap ----------------
    bus_write(32'h00, 32'h0);
    bus_write(32'h20, 32'h0040_0000);
    bus_write(32'h24, 32'h0000_0000);
    bus_write(32'h28, 32'h00FF_FFFF);
    read_check("manual_no_update", 32'h40, 32'h0012_3456);
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!hit) begin
        @(negedge clk_i);
        hit = (tb_cnt == 8'd100);
      end
    end
    check("commit_sync_wait", {31'd0, hit}, 32'd1);
    bus_write(32'h00, 32'h2);
    read_check("commit_pending", 32'h04, 32'h0000_0100);
    check("commit_busy", {31'd0, busy_o}, 32'd1);
    bus_write(32'h00, 32'h2);
    read_check("commit_again", 32'h04, 32'h0000_0100);
    read_check("commit_ctrl_rd0", 32'h00, 32'h0);
    check("commit_hold", ch_val(0), 32'h0012_3456);
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!hit) begin
        @(negedge clk_i);
        if (ch_val(0) != 32'h0012_3456) begin
          hit = 1'b1;
          check("commit_at_wrap", {24'd0, tb_cnt}, 32'd1);
        end
      end
    end
    check("commit_seen", {31'd0, hit}, 32'd1);
    check("commit_ch0", ch_val(0), 32'h0040_0000);
    check("commit_ch1", ch_val(1), 32'h0000_0000);
    check("commit_ch2", ch_val(2), 32'h00FF_FFFF);
    check("commit_ch3", ch_val(3), 32'h009B_8000);
    read_check("commit_cleared", 32'h04, 32'h0);
    check("commit_busy_clr", {31'd0, busy_o}, 32'd0);

    // ---------------- PWM duty over one full frame ----------------
    for (int n = 0; n < CH; n++) hi[n] = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk_i);
      for (int n = 0; n < CH; n++) hi[n] += int'(pwm_o[n]);
    end
    check("pwm_ch0_64", hi[0], 32'd64);
    check("pwm_ch1_zero", hi[1], 32'd0);
    check("pwm_ch2_max", hi[2], 32'd255);
    check("pwm_ch3_155", hi[3], 32'd155);

    // ---------------- reset mid-ramp ----------------
    bus_write(32'h00, 32'h1);
    bus_write(32'h08, 32'h0000_0100);
    bus_write(32'h2C, 32'h0);
    repeat (10) @(negedge clk_i);
    check("ramp_busy", {31'd0, busy_o}, 32'd1);
    check("ramp_moving", {31'd0, ch_val(3) != 32'h009B_8000}, 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    for (int n = 0; n < CH; n++) check("rst2_dac", ch_val(n), 32'(RST_VAL[n*DW +: DW]));
    check("rst2_busy", {31'd0, busy_o}, 32'd0);
    check("rst2_pwm", {28'd0, pwm_o}, 32'd0);
    check("rst2_ack", {31'd0, sys_ack}, 32'd0);
    check("rst2_rdata", sys_rdata, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("rst2_no_ramp", ch_val(3), 32'h009C_0000);
    check("rst2_busy_idle", {31'd0, busy_o}, 32'd0);
    read_check("rst2_status", 32'h04, 32'h0);
    read_check("rst2_ctrl", 32'h00, 32'h0);
    read_check("rst2_step", 32'h08, 32'h0);
    read_check("rst2_shadow3", 32'h2C, 32'h009C_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
